// File: rtl/ssd_display_driver.sv
// Binary-to-BCD (sequential double-dabble) converter driving a 4-digit common-anode seven-segment display.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading-zero digits (units digit always shown).
module ssd_display_driver #(
   parameter int IN_WIDTH    = 13,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_WIDTH-1:0] value,
   output logic [3:0]          anode,
   output logic [6:0]          cathode,
   output logic                busy
);

   localparam int            CW        = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [3:0]    ITER_LAST = 4'(IN_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t              state, state_next;
   logic                capture, do_shift, do_latch;
   logic                force_flag;
   logic [IN_WIDTH-1:0] shift_reg, cap_value, last_captured;
   logic [15:0]         bcd, bcd_adj;
   logic [15+IN_WIDTH:0] dd_next;
   logic [3:0]          iter;
   logic [3:0]          digits [4];
   logic [CW-1:0]       cnt;
   logic [1:0]          idx;
   logic [3:0]          anode_next;
   logic [6:0]          cathode_next;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      do_shift   = 1'b0;
      do_latch   = 1'b0;
      case (state)
         IDLE: begin
            if (force_flag || (value != last_captured)) begin
               capture    = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            do_shift = 1'b1;
            if (iter == ITER_LAST) state_next = LATCH;
         end
         LATCH: begin
            do_latch   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Add-3 is confined to each nibble; a corrected nibble never exceeds 12 so no carry is lost.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
      end
      dd_next = {bcd_adj, shift_reg} << 1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         force_flag    <= 1'b1;
         shift_reg     <= '0;
         cap_value     <= '0;
         last_captured <= '0;
         bcd           <= '0;
         iter          <= '0;
         for (int i = 0; i < 4; i++) digits[i] <= '0;
      end else begin
         if (capture) begin
            force_flag <= 1'b0;
            shift_reg  <= value;
            cap_value  <= value;
            bcd        <= '0;
            iter       <= '0;
         end
         if (do_shift) begin
            bcd       <= dd_next[15+IN_WIDTH:IN_WIDTH];
            shift_reg <= dd_next[IN_WIDTH-1:0];
            iter      <= iter + 4'd1;
         end
         if (do_latch) begin
            for (int i = 0; i < 4; i++) digits[i] <= bcd[4*i +: 4];
            last_captured <= cap_value;
         end
      end
   end

   always_comb begin
      anode_next   = ~(4'b0001 << idx);
      cathode_next = seg_code(digits[idx]);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      begin
         logic [3:0] lz;
         lz[3] = (digits[3] == 4'd0);
         lz[2] = lz[3] && (digits[2] == 4'd0);
         lz[1] = lz[2] && (digits[1] == 4'd0);
         lz[0] = 1'b0;
         if (lz[idx]) cathode_next = 7'b1111111;
      end
`endif
   end

   // Anode and cathode register on the same edge so a digit never shows another digit's segments.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         idx     <= '0;
         anode   <= 4'b1111;
         cathode <= 7'b1111111;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         anode   <= anode_next;
         cathode <= cathode_next;
      end
   end

endmodule
